sdpram_pipelined: RTL and testbench
===================================

SDPRAM_PIPELINED -- requirements
Module: sdpram_pipelined

Interface
REQ-001 Parameter DATA_WIDTH, default 32: word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter MEM_DEPTH, default 256: number of words; any value >= 2.
REQ-003 Parameter RD_LATENCY, default 2: cycles from renb accepted to dvalb; legal range 1..4.
REQ-004 Parameter INIT_VALUE, default all ones: word written to every location by the init sweep.
REQ-005 Derived ADDR_WIDTH = $clog2(MEM_DEPTH); NB = DATA_WIDTH/8.
REQ-006 clk  input  1  single clock; all logic on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 wena  input  1  write request, port A.
REQ-009 addra  input  ADDR_WIDTH  write address.
REQ-010 dina  input  DATA_WIDTH  write data.
REQ-011 bena  input  NB  byte-lane write enables; bit i gates dina[8i+7:8i].
REQ-012 renb  input  1  read request, port B.
REQ-013 addrb  input  ADDR_WIDTH  read address.
REQ-014 doutb  output  DATA_WIDTH  read data.
REQ-015 dvalb  output  1  doutb valid strobe, one cycle per accepted read.
REQ-016 init_busy  output  1  high while the init sweep runs.

Function
REQ-017 FSM states INIT and READY; INIT -> READY after the write to location MEM_DEPTH-1; READY -> INIT only on rst.
REQ-018 INIT: one location per cycle, counter 0..MEM_DEPTH-1, INIT_VALUE written; sweep takes exactly MEM_DEPTH cycles after rst deasserts.
REQ-019 In INIT, wena and renb are ignored; no request queued; dvalb stays 0.
REQ-020 READY write: when wena=1, only lanes with bena[i]=1 update mem[addra]; new data is visible to reads issued in the next cycle.
REQ-021 READY read: renb=1 in cycle N accepted unconditionally; doutb = mem[addrb] sampled at N, dvalb=1 in cycle N+RD_LATENCY.
REQ-022 Pipeline never stalls; renb may be high every cycle; one dvalb per accepted read, in issue order.
REQ-023 doutb holds the last completed read data while dvalb=0.
REQ-024 Same-address read and write in the same cycle: behaviour per REQ-031/032.
REQ-025 Address >= MEM_DEPTH (non-power-of-2 depth): write dropped; read completes with dvalb=1 and doutb=INIT_VALUE.
REQ-026 Illegal DATA_WIDTH or RD_LATENCY SHALL halt elaboration with a $fatal message.

Reset
REQ-027 rst=1 at any clock edge: FSM -> INIT, init counter -> 0, read pipeline flushed.
REQ-028 During and after rst: doutb=0, dvalb=0, init_busy=1.
REQ-029 Reset mid-sweep or mid-read restarts the sweep from 0; in-flight reads produce no dvalb.
REQ-030 Memory contents are defined only by the sweep; no separate array clear.

Configuration
REQ-031 SDPRAM_BYPASS_EN defined: same-cycle same-address read returns the byte-merged new word (write-first forwarding).
REQ-032 SDPRAM_BYPASS_EN undefined: same-cycle same-address read returns the pre-write word (read-first); no forwarding logic built.

Structure
REQ-033 Package sdpram_pkg holds the default DATA_WIDTH/MEM_DEPTH/RD_LATENCY constants and the FSM state enum typedef (INIT, READY).
REQ-034 Sub-module sdpram_rd_pipe: RD_LATENCY-stage data+valid shift pipeline with synchronous flush, instantiated once.

Verification
REQ-035 rst for 2 cycles, MEM_DEPTH=16 -> init_busy high exactly 16 cycles after release; reads of all 16 addresses return FFFFFFFF.
REQ-036 Write 0x12345678 to addr 5 with bena=4'b0101 over INIT_VALUE -> read addr 5 returns FF34FF78 with dvalb exactly RD_LATENCY=2 cycles after renb.
REQ-037 renb high 8 consecutive cycles, addrb 0..7 pre-written with addr*0x11 -> 8 consecutive dvalb pulses, data 00,11,..,77 in order.
REQ-038 Same cycle wena addr 3 = 0xAAAA5555 and renb addr 3 (old 0x0) -> doutb 0x0 without SDPRAM_BYPASS_EN, 0xAAAA5555 with it.
REQ-039 rst asserted 1 cycle after 3 reads issued and during a sweep at count 7 -> no dvalb from those reads; sweep restarts at 0, init_busy high MEM_DEPTH cycles.
REQ-040 MEM_DEPTH=12, write addr 13 = 0x1, read addr 13 -> write dropped, dvalb=1 with doutb FFFFFFFF; mem[1] unchanged.

Source files
------------

// File: rtl/sdpram_pkg.sv
// Shared defaults and FSM state encoding for the pipelined simple dual-port RAM.
package sdpram_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MEM_DEPTH  = 256;
  localparam int DEF_RD_LATENCY = 2;
  localparam int MAX_RD_LATENCY = 4;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } sdpram_state_e;

endpackage

// File: rtl/sdpram_if.sv
// Write port A, read port B and status bundle of the pipelined simple dual-port RAM.
interface sdpram_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  localparam int NB = DATA_WIDTH / 8;

  logic                  wena;
  logic [ADDR_WIDTH-1:0] addra;
  logic [DATA_WIDTH-1:0] dina;
  logic [NB-1:0]         bena;
  logic                  renb;
  logic [ADDR_WIDTH-1:0] addrb;
  logic [DATA_WIDTH-1:0] doutb;
  logic                  dvalb;
  logic                  init_busy;

  modport master (
    output wena, addra, dina, bena, renb, addrb,
    input  doutb, dvalb, init_busy
  );

  modport slave (
    input  wena, addra, dina, bena, renb, addrb,
    output doutb, dvalb, init_busy
  );
endinterface

// File: rtl/sdpram_rd_pipe.sv
// Read-data shift pipeline: LATENCY stages of valid+data, synchronous flush clears every stage.
// Latency LATENCY cycles in to out; no backpressure, last-stage data holds between valid beats.
module sdpram_rd_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  flush,
  input  logic                  in_vld,
  input  logic [DATA_WIDTH-1:0] in_dat,
  output logic                  out_vld,
  output logic [DATA_WIDTH-1:0] out_dat
);

  logic [LATENCY-1:0]    vld_q;
  logic [DATA_WIDTH-1:0] dat_q [LATENCY];

  // Data only moves alongside a valid beat, so the final stage keeps the last
  // completed word while no read is arriving.
  always_ff @(posedge clk) begin
    if (flush) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= in_vld;
      if (in_vld) begin
        dat_q[0] <= in_dat;
      end
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          dat_q[i] <= dat_q[i-1];
        end
      end
    end
  end

  assign out_vld = vld_q[LATENCY-1];
  assign out_dat = dat_q[LATENCY-1];

endmodule

// File: rtl/sdpram_pipelined.sv
// Simple dual-port RAM with byte-lane writes, post-reset INIT_VALUE sweep and RD_LATENCY read pipe;
// no backpressure (a read may issue every cycle). SDPRAM_BYPASS_EN selects write-first same-address reads.
module sdpram_pipelined
  import sdpram_pkg::*;
#(
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int                    MEM_DEPTH  = DEF_MEM_DEPTH,
  parameter int                    RD_LATENCY = DEF_RD_LATENCY,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '1
) (
  input  logic     clk,
  input  logic     rst,
  sdpram_if.slave  bus
);

  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);
  localparam int NB         = DATA_WIDTH / 8;

  localparam logic [0:0] ST_INIT  = INIT;
  localparam logic [0:0] ST_READY = READY;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  if ((DATA_WIDTH < 8) || ((DATA_WIDTH % 8) != 0)) begin : g_bad_data_width
    $fatal(1, "sdpram_pipelined: DATA_WIDTH=%0d must be a positive multiple of 8", DATA_WIDTH);
  end
  if ((RD_LATENCY < 1) || (RD_LATENCY > MAX_RD_LATENCY)) begin : g_bad_rd_latency
    $fatal(1, "sdpram_pipelined: RD_LATENCY=%0d outside 1..%0d", RD_LATENCY, MAX_RD_LATENCY);
  end
  if (MEM_DEPTH < 2) begin : g_bad_depth
    $fatal(1, "sdpram_pipelined: MEM_DEPTH=%0d must be at least 2", MEM_DEPTH);
  end

  logic [0:0]            state_q;
  logic [ADDR_WIDTH-1:0] init_cnt_q;
  logic                  in_init;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else if (state_q == ST_INIT) begin
      if (init_cnt_q == LAST_ADDR) begin
        state_q <= ST_READY;
      end else begin
        init_cnt_q <= init_cnt_q + 1'b1;
      end
    end
  end

  assign in_init       = (state_q == ST_INIT);
  assign bus.init_busy = in_init;

  // Non-power-of-2 depths leave a hole at the top of the address space.
  logic wa_in_range;
  logic rb_in_range;

  assign wa_in_range = ({1'b0, bus.addra} < DEPTH_EXT);
  assign rb_in_range = ({1'b0, bus.addrb} < DEPTH_EXT);

  logic                  wr_vld;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_dat;
  logic [NB-1:0]         wr_be;

  always_comb begin
    wr_vld  = 1'b0;
    wr_addr = bus.addra;
    wr_dat  = bus.dina;
    wr_be   = bus.bena;
    if (!rst) begin
      if (in_init) begin
        wr_vld  = 1'b1;
        wr_addr = init_cnt_q;
        wr_dat  = INIT_VALUE;
        wr_be   = '1;
      end else begin
        wr_vld  = bus.wena && wa_in_range;
      end
    end
  end

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_vld) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][8*i +: 8] <= wr_dat[8*i +: 8];
        end
      end
    end
  end

  logic                  rd_vld;
  logic [DATA_WIDTH-1:0] rd_dat;

  assign rd_vld = bus.renb && !in_init && !rst;

  always_comb begin
    rd_dat = rb_in_range ? mem[bus.addrb] : INIT_VALUE;
`ifdef SDPRAM_BYPASS_EN
    // Write-first: lanes written this cycle to the same word are forwarded.
    if (bus.wena && wa_in_range && (bus.addra == bus.addrb)) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.bena[i]) begin
          rd_dat[8*i +: 8] = bus.dina[8*i +: 8];
        end
      end
    end
`endif
  end

  sdpram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (RD_LATENCY)
  ) u_rd_pipe (
    .clk     (clk),
    .flush   (rst),
    .in_vld  (rd_vld),
    .in_dat  (rd_dat),
    .out_vld (bus.dvalb),
    .out_dat (bus.doutb)
  );

endmodule

// File: tb/tb_sdpram_pipelined.sv
// Directed bench: 16-deep latency-2 instance driven from a vector table, 12-deep latency-4 instance
// for out-of-range addressing and reset-during-sweep/in-flight-read sequences.
module tb_sdpram_pipelined;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  sdpram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus_a ();
  sdpram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus_b ();

  sdpram_pipelined #(
    .DATA_WIDTH (32),
    .MEM_DEPTH  (16),
    .RD_LATENCY (2),
    .INIT_VALUE (32'hFFFF_FFFF)
  ) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  sdpram_pipelined #(
    .DATA_WIDTH (32),
    .MEM_DEPTH  (12),
    .RD_LATENCY (4),
    .INIT_VALUE (32'hFFFF_FFFF)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

`ifdef SDPRAM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic        wena;
    logic [3:0]  addra;
    logic [31:0] dina;
    logic [3:0]  bena;
    logic        renb;
    logic [3:0]  addrb;
    logic        exp_vld;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                              input logic [3:0] be, input logic re, input logic [3:0] ra,
                              input logic ev, input logic [31:0] ed);
    vec_t v;
    v.wena = we; v.addra = wa; v.dina = wd; v.bena = be;
    v.renb = re; v.addrb = ra; v.exp_vld = ev; v.exp_dat = ed;
    vecs.push_back(v);
  endfunction

  task automatic idle_a();
    bus_a.wena = 1'b0; bus_a.addra = '0; bus_a.dina = '0; bus_a.bena = '0;
    bus_a.renb = 1'b0; bus_a.addrb = '0;
  endtask

  task automatic idle_b();
    bus_b.wena = 1'b0; bus_b.addra = '0; bus_b.dina = '0; bus_b.bena = '0;
    bus_b.renb = 1'b0; bus_b.addrb = '0;
  endtask

  initial begin
    int n;
    bit seen;
    logic [31:0] same_addr_old;
    logic [31:0] lane_merge;

    // Each entry is driven for one cycle; the expected columns are the outputs
    // seen one edge later, i.e. the read issued in the previous entry completes.
    for (int k = 0; k < 16; k++) begin
      add(0, 4'h0, 32'h0, 4'h0, 1, 4'(k), (k != 0), (k != 0) ? 32'hFFFF_FFFF : 32'h0);
    end
    add(0, 4'h0, 32'h0, 4'h0, 0, 4'h0, 1, 32'hFFFF_FFFF);
    add(0, 4'h0, 32'h0, 4'h0, 0, 4'h0, 0, 32'hFFFF_FFFF);
    add(1, 4'h5, 32'h1234_5678, 4'b0101, 0, 4'h0, 0, 32'hFFFF_FFFF);
    add(0, 4'h0, 32'h0, 4'h0, 1, 4'h5, 0, 32'hFFFF_FFFF);
    add(0, 4'h0, 32'h0, 4'h0, 0, 4'h0, 1, 32'hFF34_FF78);
    add(0, 4'h0, 32'h0, 4'h0, 0, 4'h0, 0, 32'hFF34_FF78);
    for (int k = 0; k < 8; k++) begin
      add(1, 4'(k), 32'(k) * 32'h11, 4'hF, 0, 4'h0, 0, 32'hFF34_FF78);
    end
    for (int k = 0; k < 8; k++) begin
      add(0, 4'h0, 32'h0, 4'h0, 1, 4'(k), (k != 0),
          (k != 0) ? 32'(k - 1) * 32'h11 : 32'hFF34_FF78);
    end
    add(0, 4'h0, 32'h0, 4'h0, 0, 4'h0, 1, 32'h77);
    add(0, 4'h0, 32'h0, 4'h0, 0, 4'h0, 0, 32'h77);
    same_addr_old = BYP ? 32'hAAAA_5555 : 32'h0;
    add(1, 4'h3, 32'h0, 4'hF, 0, 4'h0, 0, 32'h77);
    add(1, 4'h3, 32'hAAAA_5555, 4'hF, 1, 4'h3, 0, 32'h77);
    add(0, 4'h0, 32'h0, 4'h0, 0, 4'h0, 1, same_addr_old);
    add(0, 4'h0, 32'h0, 4'h0, 1, 4'h3, 0, same_addr_old);
    add(0, 4'h0, 32'h0, 4'h0, 0, 4'h0, 1, 32'hAAAA_5555);
    lane_merge = BYP ? 32'hDE00_0066 : 32'h0000_0066;
    add(1, 4'h6, 32'hDEAD_BEEF, 4'b1000, 1, 4'h6, 0, 32'hAAAA_5555);
    add(0, 4'h0, 32'h0, 4'h0, 0, 4'h0, 1, lane_merge);
    add(0, 4'h0, 32'h0, 4'h0, 0, 4'h0, 0, lane_merge);

    idle_a();
    idle_b();
    rst_a = 1'b1;
    rst_b = 1'b1;
    tick();
    tick();
    check("reset doutb", bus_a.doutb, 32'h0);
    check("reset dvalb", 32'(bus_a.dvalb), 32'h0);
    check("reset init_busy", 32'(bus_a.init_busy), 32'h1);

    // Sweep length after release; reads requested during the sweep must be ignored.
    rst_a = 1'b0;
    rst_b = 1'b0;
    bus_a.renb  = 1'b1;
    bus_a.addrb = 4'h3;
    n = 0;
    seen = 1'b0;
    while (bus_a.init_busy && n < 100) begin
      n++;
      if (bus_a.dvalb) seen = 1'b1;
      tick();
    end
    idle_a();
    check("sweep cycles a", 32'(n), 32'd16);
    tick();
    if (bus_a.dvalb) seen = 1'b1;
    tick();
    if (bus_a.dvalb) seen = 1'b1;
    check("no dvalb from init reads", 32'(seen), 32'h0);

    foreach (vecs[i]) begin
      bus_a.wena  = vecs[i].wena;
      bus_a.addra = vecs[i].addra;
      bus_a.dina  = vecs[i].dina;
      bus_a.bena  = vecs[i].bena;
      bus_a.renb  = vecs[i].renb;
      bus_a.addrb = vecs[i].addrb;
      tick();
      check($sformatf("vec%0d dvalb", i), 32'(bus_a.dvalb), 32'(vecs[i].exp_vld));
      check($sformatf("vec%0d doutb", i), bus_a.doutb, vecs[i].exp_dat);
    end
    idle_a();

    // Depth 12, latency 4: write to hole address 13 dropped, read of 13 returns INIT_VALUE,
    // and address 1 (13 mod 12) keeps its swept value.
    check("sweep done b", 32'(bus_b.init_busy), 32'h0);
    bus_b.wena = 1'b1; bus_b.addra = 4'd13; bus_b.dina = 32'h1; bus_b.bena = 4'hF;
    tick();
    idle_b();
    bus_b.renb = 1'b1; bus_b.addrb = 4'd13;
    tick();
    bus_b.addrb = 4'd1;
    check("oob lat c2 dvalb", 32'(bus_b.dvalb), 32'h0);
    tick();
    bus_b.renb = 1'b0;
    check("oob lat c3 dvalb", 32'(bus_b.dvalb), 32'h0);
    tick();
    check("oob lat c4 dvalb", 32'(bus_b.dvalb), 32'h0);
    check("oob lat c4 doutb", bus_b.doutb, 32'h0);
    tick();
    check("oob read dvalb", 32'(bus_b.dvalb), 32'h1);
    check("oob read doutb", bus_b.doutb, 32'hFFFF_FFFF);
    tick();
    check("mem1 read dvalb", 32'(bus_b.dvalb), 32'h1);
    check("mem1 unchanged", bus_b.doutb, 32'hFFFF_FFFF);
    tick();
    check("oob tail dvalb", 32'(bus_b.dvalb), 32'h0);
    check("oob tail doutb", bus_b.doutb, 32'hFFFF_FFFF);

    // Three reads in flight when reset lands; then reset again at sweep count 7.
    seen = 1'b0;
    bus_b.renb = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus_b.addrb = 4'(k);
      tick();
      if (bus_b.dvalb) seen = 1'b1;
    end
    idle_b();
    rst_b = 1'b1;
    tick();
    check("rst flush dvalb", 32'(bus_b.dvalb), 32'h0);
    check("rst flush doutb", bus_b.doutb, 32'h0);
    check("rst flush init_busy", 32'(bus_b.init_busy), 32'h1);
    rst_b = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (bus_b.dvalb) seen = 1'b1;
    end
    check("mid sweep busy", 32'(bus_b.init_busy), 32'h1);
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    n = 0;
    while (bus_b.init_busy && n < 100) begin
      n++;
      if (bus_b.dvalb) seen = 1'b1;
      tick();
    end
    check("restart sweep cycles b", 32'(n), 32'd12);
    check("no dvalb from flushed reads", 32'(seen), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
